rom_stream_reader: RTL and testbench
====================================

Name: rom_stream_reader

Overview:
- Upstream sequencer for the synchronous ROM stage, which registers `data <= mem[pointer]` on each clock, so its read latency is 1 cycle.
- On a start command, walks `length` consecutive ROM addresses from `base_addr`, drives the ROM `pointer` input and captures the returned `data`.
- Emits the words as a valid/ready stream with a last-word flag, for the pixel/sprite path.
- Absorbs ROM latency under backpressure with a 2-entry buffer.

Parameters:
- ADDR_W, 4, ROM address width; ROM depth is 2^ADDR_W.
- DATA_W, 8, ROM data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first ROM address; sampled with start.
- length  in  ADDR_W+1  number of words to read, 0..2^ADDR_W; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- rom_addr  out  ADDR_W  drives the ROM `pointer`.
- rom_data  in  DATA_W  from the ROM `data`; equals mem[rom_addr of the previous cycle].
- out_data  out  DATA_W  stream payload.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  qualifies the final word of the command (valid only with out_valid).

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: busy=0, done=0, rom_addr=0, out_valid=0, out_last=0, out_data=0. Buffer is emptied, in-flight read is discarded, state is IDLE.
- Reset mid-command aborts the command: no done pulse, no further output words.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with length!=0 → RUN. Latch addr=base_addr, issue_cnt=length, emit_cnt=length.
  - start=1 with length=0 → stay IDLE, done=1 next cycle, no stream output.
- RUN: issue a read in cycle t when issue_cnt>0 and (buffer occupancy + in-flight) < 2.
  - An issue registers rom_addr=addr in cycle t, then addr += 1 mod 2^ADDR_W and issue_cnt -= 1.
  - rom_data is captured into the buffer at the end of cycle t+1.
  - rom_addr holds its last value when not issuing.
  - When issue_cnt reaches 0 → DRAIN.
- DRAIN:
  - When the buffer is empty, nothing is in flight and the last word has been accepted → IDLE with done=1 for 1 cycle. busy falls in the same cycle done rises.
- Stream rules:
  - A word transfers when out_valid & out_ready.
  - out_data, out_valid and out_last stay stable while out_valid=1 and out_ready=0.
  - out_last=1 exactly on the word for which emit_cnt==1.
  - Words appear in address order, never duplicated or dropped.
- Latency: start sampled at cycle T; first rom_addr at T+1; data captured at T+2; out_valid=1 at T+3.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, at most 2 words are buffered and issue stalls. When ready returns, streaming resumes with no bubble beyond the refill.
- Simultaneous buffer push and pop are allowed.
- Address wrap: base_addr=2^ADDR_W-2 with length=4 reads addresses 14, 15, 0, 1 (for ADDR_W=4).
- length=2^ADDR_W reads every location exactly once.
- start while busy is ignored, with no effect on the running command.
- start in the same cycle as done is not accepted (the FSM is not yet in IDLE).

Decomposition:
- Shared package gfx_stream_pkg holds:
  - localparams for the default ADDR_W/DATA_W;
  - the FSM state enum `rsr_state_t` {IDLE, RUN, DRAIN};
  - a stream beat struct {data, last}.
- One sub-module: rsr_skid_fifo, a 2-entry FIFO with push/pop, full/empty and occupancy outputs, and synchronous reset. It is reusable by later stream stages.
- The top level holds the FSM, counters and credit logic.

Test Plan:
- ROM loaded with mem[i]=8'hA0+i; start base=0 length=4, out_ready=1 → out_data A0,A1,A2,A3 on cycles T+3..T+6; out_last on A3; done at T+7; busy=0 after.
- base=14 length=4 → addresses 14,15,0,1 on rom_addr; data AE,AF,A0,A1; last on A1.
- length=0 → done pulse 1 cycle after start; out_valid never asserted; rom_addr unchanged.
- base=0 length=6; out_ready toggled 0,0,1,0,1,1,... → exactly A0..A5 in order; no loss or duplication; payload stable while stalled; never more than 2 outstanding reads.
- rst=1 asserted at the 2nd output beat of a length=8 command → next cycle out_valid=0, busy=0, no done. A fresh start base=3 length=2 then yields A3,A4.
- start re-pulsed with base=9 while busy → ignored; original sequence completes unchanged; a full-depth length=16 read returns all 16 words once each.

Source files
------------

// File: rtl/gfx_stream_pkg.sv
// ============================================================================
// gfx_stream_pkg: shared types and defaults for the pixel/sprite stream path
// Rev 1.0
// ============================================================================
`default_nettype none

package gfx_stream_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rsr_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } gfx_beat_t;

endpackage

`default_nettype wire

// File: rtl/rsr_skid_fifo.sv
// ============================================================================
// rsr_skid_fifo: 2-entry FIFO; push while full is accepted only with a pop
// Rev 1.0
// ============================================================================
`default_nettype none

module rsr_skid_fifo #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_stream_reader.sv
// ============================================================================
// rom_stream_reader: walks ROM addresses and streams words out valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module rom_stream_reader
  import gfx_stream_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  rsr_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_issue_cnt;
  logic [ADDR_W:0]   r_cap_cnt;
  logic [ADDR_W:0]   r_emit_cnt;
  logic              r_req;
  logic              r_data_vld;

  logic              w_start_go;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_count;
  logic [1:0]        w_occ_next;
  logic [DATA_W:0]   w_push_beat;
  logic [DATA_W:0]   w_head;

  // r_req: rom_addr carries a fresh read this cycle. r_data_vld: rom_data holds
  // an uncaptured word. While rom_addr is held, the ROM keeps re-presenting the
  // same word, so a word may wait in the ROM register until the FIFO has room.
  assign w_start_go = (r_state == IDLE) && start && (length != '0);
  assign w_pop      = !w_empty && out_ready;
  assign w_push     = r_data_vld && (!w_full || w_pop);
  assign w_occ_next = w_count + {1'b0, w_push} - {1'b0, w_pop};

  // A new read forces the word arriving next cycle to be captured, so only
  // issue when the FIFO is guaranteed a free slot next cycle.
  assign w_issue     = (r_state == RUN) && (r_issue_cnt != '0) && (w_occ_next < 2'd2);
  assign w_push_beat = {(r_cap_cnt == CNT_ONE), rom_data};

  rsr_skid_fifo #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_beat),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_head[DATA_W-1:0];
  assign out_last  = w_head[DATA_W] && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_addr    <= '0;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_emit_cnt  <= '0;
      r_req       <= 1'b0;
      r_data_vld  <= 1'b0;
    end else begin
      done       <= 1'b0;
      r_req      <= w_start_go || w_issue;
      r_data_vld <= r_req || (r_data_vld && !w_push);

      if (w_push) begin
        r_cap_cnt <= r_cap_cnt - CNT_ONE;
      end
      if (w_pop) begin
        r_emit_cnt <= r_emit_cnt - CNT_ONE;
      end
      if (w_issue) begin
        rom_addr    <= r_addr;
        r_addr      <= r_addr + ADDR_ONE;
        r_issue_cnt <= r_issue_cnt - CNT_ONE;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              // The accepting edge already launches the first read.
              r_state     <= RUN;
              busy        <= 1'b1;
              rom_addr    <= base_addr;
              r_addr      <= base_addr + ADDR_ONE;
              r_issue_cnt <= length - CNT_ONE;
              r_cap_cnt   <= length;
              r_emit_cnt  <= length;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if ((r_issue_cnt == '0) || (w_issue && (r_issue_cnt == CNT_ONE))) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && (r_emit_cnt == CNT_ONE)) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
// ============================================================================
// tb_rom_stream_reader: scoreboard bench for rom_stream_reader with a ROM model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rom_stream_reader;
  import gfx_stream_pkg::*;

  localparam int ADDR_W = DEF_ADDR_W;
  localparam int DATA_W = DEF_DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  int n_checks = 0;
  int n_fail   = 0;

  gfx_beat_t         exp_q[$];
  gfx_beat_t         mon_b;
  logic              hold_pend = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;

  logic [DATA_W-1:0] rom_mem [DEPTH];

  always #5 clk = ~clk;

  // One-cycle-latency synchronous ROM
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  rom_stream_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_expect(input int b, input int l);
    gfx_beat_t e;
    for (int i = 0; i < l; i++) begin
      e.data = DATA_W'(32'hA0 + ((b + i) % DEPTH));
      e.last = (i == l - 1);
      exp_q.push_back(e);
    end
  endtask

  // Returns 1 ns after the edge that samples start (inside cycle T+1).
  task automatic start_cmd(input int b, input int l, input bit expect_out);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    length    = (ADDR_W+1)'(l);
    if (expect_out) push_expect(b, l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle-exact profile of a command with out_ready held high.
  task automatic timing_check(input int b, input int l);
    for (int c = 1; c <= l + 4; c++) begin
      @(negedge clk);
      check_val("busy_t", 32'(busy), 32'(c <= l + 2));
      check_val("valid_t", 32'(out_valid), 32'(c >= 3 && c <= l + 2));
      check_val("done_t", 32'(done), 32'(c == l + 3));
      check_val("rom_addr_t", 32'(rom_addr), 32'((b + ((c <= l) ? c - 1 : l - 1)) % DEPTH));
    end
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_val("done_seen", 32'(seen), 32'd1);
    check_val("busy_at_done", 32'(busy), 32'd0);
  endtask

  // Stream monitor: scoreboard pop on each transfer, stability while stalled.
  always @(negedge clk) begin
    if (hold_pend && !rst) begin
      check_val("stall_valid", 32'(out_valid), 32'd1);
      check_val("stall_data", 32'(out_data), 32'(hold_data));
      check_val("stall_last", 32'(out_last), 32'(hold_last));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("extra_beat", 32'd1, 32'd0);
      end else begin
        mon_b = exp_q.pop_front();
        check_val("beat_data", 32'(out_data), 32'(mon_b.data));
        check_val("beat_last", 32'(out_last), 32'(mon_b.last));
      end
    end
    hold_pend = out_valid && !out_ready && !rst;
    hold_data = out_data;
    hold_last = out_last;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit bp_pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit seen;

    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DATA_W'(32'hA0 + i);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_last", 32'(out_last), 32'd0);
    check_val("rst_data", 32'(out_data), 32'd0);
    check_val("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic read, full throughput
    start_cmd(0, 4, 1'b1);
    timing_check(0, 4);
    check_val("sb_empty_basic", 32'(exp_q.size()), 32'd0);

    // Zero-length command: immediate done, no output, rom_addr untouched
    start_cmd(5, 0, 1'b0);
    @(negedge clk);
    check_val("len0_done", 32'(done), 32'd1);
    check_val("len0_busy", 32'(busy), 32'd0);
    check_val("len0_valid", 32'(out_valid), 32'd0);
    check_val("len0_rom_addr", 32'(rom_addr), 32'd3);
    @(negedge clk);
    check_val("len0_done_pulse", 32'(done), 32'd0);
    check_val("len0_valid2", 32'(out_valid), 32'd0);

    // Address wrap 14,15,0,1
    start_cmd(14, 4, 1'b1);
    timing_check(14, 4);
    check_val("sb_empty_wrap", 32'(exp_q.size()), 32'd0);

    // Backpressure pattern
    start_cmd(0, 6, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      out_ready = bp_pat[i % 6];
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_val("bp_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    check_val("sb_empty_bp", 32'(exp_q.size()), 32'd0);

    // Reset during the second output beat
    start_cmd(0, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("abort_valid", 32'(out_valid), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_done", 32'(done), 32'd0);
    end
    check_val("abort_beats_taken", 32'(8 - exp_q.size()), 32'd2);
    exp_q.delete();
    start_cmd(3, 2, 1'b1);
    wait_done(40);
    check_val("sb_empty_after_rst", 32'(exp_q.size()), 32'd0);

    // start while busy is ignored
    start_cmd(0, 5, 1'b1);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = ADDR_W'(9);
    length    = (ADDR_W+1)'(3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40);
    check_val("busy_start_rom_addr", 32'(rom_addr), 32'd4);
    repeat (6) begin
      @(negedge clk);
      check_val("busy_start_no_extra", 32'(out_valid), 32'd0);
    end
    check_val("sb_empty_busy", 32'(exp_q.size()), 32'd0);

    // Full-depth read
    start_cmd(7, DEPTH, 1'b1);
    timing_check(7, DEPTH);
    check_val("sb_empty_full", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
